// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants and the serializer state encoding.
package dlfloat_pkg;
    localparam int DLF_W      = 16;
    localparam int DLF_EXP_W  = 6;
    localparam int DLF_MANT_W = 9;

    localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

    typedef enum logic [1:0] {IDLE, MSB, LSB} ser_state_t;
endpackage

// File: rtl/dlfloat_sync_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; head shown combinationally.
module dlfloat_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;
endmodule

// File: rtl/dlfloat_result_serializer.sv
// Buffers DLFloat16 MAC results and streams them as framed MSB-first byte pairs.
module dlfloat_result_serializer
    import dlfloat_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DLF_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     res_valid,
    input  logic [W-1:0]             res_data,
    output logic                     res_ready,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     byte_last,
    output logic                     flag_nan,
    output logic                     flag_zero,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow_err,
    input  logic                     err_clr
);
    ser_state_t   state, state_nxt;
    logic [W-1:0] hold;
    logic [W-1:0] fifo_dout;
    logic         fifo_full, fifo_empty, pop;

    assign res_ready = !fifo_full;

    dlfloat_sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_valid && res_ready),
        .pop   (pop),
        .din   (res_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_out   = 8'h00;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = MSB;
                end
            end
            MSB: begin
                byte_valid = 1'b1;
                byte_out   = hold[W-1:W-8];
                if (byte_ready) state_nxt = LSB;
            end
            LSB: begin
                byte_valid = 1'b1;
                byte_last  = 1'b1;
                byte_out   = hold[7:0];
                // Chain straight into the next frame so there is no idle bubble.
                if (byte_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = MSB;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            flag_nan  <= 1'b0;
            flag_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                hold      <= fifo_dout;
                flag_nan  <= (fifo_dout == DLF_NAN);
                flag_zero <= (fifo_dout == DLF_ZERO);
            end else if (state_nxt == IDLE) begin
                flag_nan  <= 1'b0;
                flag_zero <= 1'b0;
            end
        end
    end

    // A drop in the same cycle as a clear must leave the error visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          overflow_err <= 1'b0;
        else if (res_valid && !res_ready) overflow_err <= 1'b1;
        else if (err_clr)                 overflow_err <= 1'b0;
    end
endmodule
